// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder data-memory block.
// Optional feature macro used by this slice: MEM_RESPONDER_BYTE_STROBE_EN
package mem_pkg;

   // Latency counter width; 4 bits covers the legal LATENCY range 1..15
   localparam int CNT_W            = 4;
   localparam int DEFAULT_WIDTH    = 32;
   localparam int DEFAULT_MEM_SIZE = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Index width for an array of n words (at least one bit)
   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// mem_array: MEM_SIZE x WIDTH register storage with per-byte write strobes,
// synchronous active-low clear, combinational read and a flat monitor bus
// (word 0 in the MSBs).
module mem_array
   import mem_pkg::*;
#(
   parameter  int WIDTH    = DEFAULT_WIDTH,
   parameter  int MEM_SIZE = DEFAULT_MEM_SIZE,
   localparam int AW       = addr_bits(MEM_SIZE),
   localparam int NB       = WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we_i,
   input  logic [AW-1:0]             addr_i,
   input  logic [WIDTH-1:0]          wdata_i,
   input  logic [NB-1:0]             be_i,
   output logic [WIDTH-1:0]          rdata_o,
   output logic [WIDTH*MEM_SIZE-1:0] bus_o
);

   logic [WIDTH-1:0] mem_q [MEM_SIZE];

   // Storage: clear every word on reset, otherwise merge strobed bytes on write
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < MEM_SIZE; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int k = 0; k < NB; k++) begin
            if (be_i[k]) begin
               mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

   generate
      for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_bus
         assign bus_o[WIDTH*(MEM_SIZE-gi)-1 -: WIDTH] = mem_q[gi];
      end
   endgenerate

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder with programmable
// latency (LATENCY legal range 1..15) and valid/ready request/response channels.
// Optional feature macro: MEM_RESPONDER_BYTE_STROBE_EN adds req_be byte strobes.
module mem_responder
   import mem_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
   parameter int LATENCY  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [WIDTH-1:0]          req_addr,
   input  logic [WIDTH-1:0]          req_wdata,
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
   input  logic [WIDTH/8-1:0]        req_be,
`endif
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [WIDTH-1:0]          resp_rdata,
   output logic                      resp_err,
   output logic [WIDTH*MEM_SIZE-1:0] out_regs_bus
);

   localparam int AW     = addr_bits(MEM_SIZE);
   localparam int NB     = WIDTH / 8;
   // With a one-cycle latency the access happens on the accept edge itself,
   // so it must use the live request instead of the latched copy.
   localparam bit DIRECT = (LATENCY == 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               we_q;
   logic [WIDTH-1:0]   addr_q;
   logic [WIDTH-1:0]   wdata_q;
   logic               req_ready_q;
   logic               resp_valid_q;
   logic [WIDTH-1:0]   rdata_q;
   logic               err_q;

   logic               accept_d;
   logic               acc_go_d;
   logic               acc_we_d;
   logic [WIDTH-1:0]   acc_addr_d;
   logic [WIDTH-1:0]   acc_wdata_d;
   logic [NB-1:0]      acc_be_d;
   logic               acc_err_d;
   logic [WIDTH-1:0]   mem_rdata;

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
   logic [NB-1:0]      be_q;
   assign acc_be_d = DIRECT ? req_be : be_q;
`else
   assign acc_be_d = '1;
`endif

   assign accept_d    = (state_q == IDLE) && req_valid;
   assign acc_go_d    = DIRECT ? accept_d : ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
   assign acc_we_d    = DIRECT ? req_we    : we_q;
   assign acc_addr_d  = DIRECT ? req_addr  : addr_q;
   assign acc_wdata_d = DIRECT ? req_wdata : wdata_q;
   // Full-width compare: high address bits never alias into the array
   assign acc_err_d   = (acc_addr_d >= WIDTH'(MEM_SIZE));

   mem_array #(
      .WIDTH    (WIDTH),
      .MEM_SIZE (MEM_SIZE)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we_i    (acc_go_d && acc_we_d && !acc_err_d),
      .addr_i  (acc_addr_d[AW-1:0]),
      .wdata_i (acc_wdata_d),
      .be_i    (acc_be_d),
      .rdata_o (mem_rdata),
      .bus_o   (out_regs_bus)
   );

   // Request/response FSM with registered handshake outputs and result capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
         be_q         <= '0;
`endif
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
                  be_q        <= req_be;
`endif
                  cnt_q       <= CNT_W'(LATENCY - 1);
                  req_ready_q <= 1'b0;
                  state_q     <= DIRECT ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != CNT_W'(1)) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // Result capture on the access edge; held until the handshake
         if (acc_go_d) begin
            resp_valid_q <= 1'b1;
            rdata_q      <= (acc_err_d || acc_we_d) ? '0 : mem_rdata;
            err_q        <= acc_err_d;
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=2 and LATENCY=4
// instances). Byte-strobe steps run when MEM_RESPONDER_BYTE_STROBE_EN is defined.
module tb_mem_responder;

   localparam int W  = 32;
   localparam int MS = 32;
   localparam int BW = W * MS;

   logic          clk = 1'b0;
   logic          rst, rst4;
   logic          req_valid, req_valid4;
   logic          req_we;
   logic [W-1:0]  req_addr, req_wdata;
   logic [3:0]    req_be;
   logic          resp_ready, resp_ready4;
   logic          req_ready, req_ready4;
   logic          resp_valid, resp_valid4;
   logic [W-1:0]  resp_rdata, resp_rdata4;
   logic          resp_err, resp_err4;
   logic [BW-1:0] bus, bus4, bus_saved;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_responder #(.WIDTH(W), .MEM_SIZE(MS), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
      .req_be(req_be),
`endif
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .out_regs_bus(bus)
   );

   mem_responder #(.WIDTH(W), .MEM_SIZE(MS), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
      .req_be(req_be),
`endif
      .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_rdata(resp_rdata4),
      .resp_err(resp_err4), .out_regs_bus(bus4)
   );

   function automatic logic [W-1:0] word_of(input logic [BW-1:0] b, input int i);
      return b[W*(MS-i)-1 -: W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present one request to the LATENCY=2 instance for exactly one accept edge
   task automatic issue(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wd);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rst4 = 1'b0;
      req_valid = 1'b0; req_valid4 = 1'b0;
      req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 4'hF;
      resp_ready = 1'b1; resp_ready4 = 1'b1;

      // 1. Reset then idle
      tick(); tick();
      rst = 1'b1; rst4 = 1'b1;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_bus_zero", bus, 0);

      // 2. Store addr 16 then load it back (LATENCY=2)
      issue(1'b1, 32'd16, 32'hDEADBEEF);
      check("st_wait_valid", resp_valid, 0);
      check("st_wait_ready", req_ready, 0);
      tick();
      check("st_resp_valid", resp_valid, 1);
      check("st_resp_err", resp_err, 0);
      check("st_resp_rdata", resp_rdata, 0);
      check("st_word16", word_of(bus, 16), 32'hDEADBEEF);
      tick();
      check("st_idle_valid", resp_valid, 0);
      check("st_idle_ready", req_ready, 1);

      issue(1'b0, 32'd16, 32'h0);
      check("ld_wait_valid", resp_valid, 0);
      tick();
      check("ld_resp_valid", resp_valid, 1);
      check("ld_resp_rdata", resp_rdata, 32'hDEADBEEF);
      check("ld_resp_err", resp_err, 0);
      tick();

      // 3. Backpressure on a load of addr 0; a store offered meanwhile is ignored
      resp_ready = 1'b0;
      issue(1'b0, 32'd0, 32'h0);
      tick();
      req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'h1111_2222; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_valid_%0d", i), resp_valid, 1);
         check($sformatf("bp_rdata_%0d", i), resp_rdata, 0);
         check($sformatf("bp_ready_%0d", i), req_ready, 0);
         tick();
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      tick();
      check("bp_release_valid", resp_valid, 0);
      check("bp_release_ready", req_ready, 1);
      check("bp_word5_untouched", word_of(bus, 5), 0);

      // 4. Out-of-range stores, including a high-bit address that must not alias
      bus_saved = bus;
      issue(1'b1, 32'd32, 32'd5);
      tick();
      check("oor_valid", resp_valid, 1);
      check("oor_err", resp_err, 1);
      check("oor_rdata", resp_rdata, 0);
      check("oor_bus", bus, bus_saved);
      tick();
      issue(1'b1, 32'h8000_0010, 32'h1234_5678);
      tick();
      check("alias_err", resp_err, 1);
      check("alias_word16", word_of(bus, 16), 32'hDEADBEEF);
      tick();

      // 5a. LATENCY=4 timing: response appears on the 4th cycle after accept
      req_we = 1'b1; req_addr = 32'd3; req_wdata = 32'h0000_00A5; req_valid4 = 1'b1;
      tick();
      req_valid4 = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check($sformatf("l4_early_valid_%0d", i), resp_valid4, 0);
         tick();
      end
      check("l4_resp_valid", resp_valid4, 1);
      check("l4_word3", word_of(bus4, 3), 32'h0000_00A5);
      tick();

      // 5b. Reset one cycle after accepting a store to addr 3
      req_we = 1'b1; req_addr = 32'd3; req_wdata = 32'hCAFE_F00D; req_valid4 = 1'b1;
      tick();
      req_valid4 = 1'b0;
      check("l4_accepted", req_ready4, 0);
      rst4 = 1'b0;
      tick();
      rst4 = 1'b1;
      check("l4_rst_ready", req_ready4, 1);
      check("l4_rst_valid", resp_valid4, 0);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            seen = seen | resp_valid4;
            tick();
         end
         check("l4_no_response", seen, 0);
      end
      check("l4_rst_word3", word_of(bus4, 3), 0);

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
      // 6. Byte strobes on the LATENCY=2 instance
      req_be = 4'b0101;
      issue(1'b1, 32'd1, 32'hFFFF_FFFF);
      tick();
      check("be_err", resp_err, 0);
      check("be_word1", word_of(bus, 1), 32'h00FF_00FF);
      tick();
      req_be = 4'b0000;
      issue(1'b1, 32'd1, 32'h1234_5678);
      tick();
      check("be_zero_err", resp_err, 0);
      check("be_zero_word1", word_of(bus, 1), 32'h00FF_00FF);
      tick();
      req_be = 4'b0000;
      issue(1'b0, 32'd1, 32'h0);
      tick();
      check("be_load_rdata", resp_rdata, 32'h00FF_00FF);
      tick();
      req_be = 4'hF;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Data-memory responder for the pipelined cpu's memory stage (cpu step 4), which issues load/store requests.
- Accepts one request at a time over a valid/ready handshake.
- Services the request against an internal MEM_SIZE x WIDTH register array after a programmable latency.
- Returns the read data or a write acknowledge over a second valid/ready channel.
- Exposes the whole array as a flat bus for bench monitoring.

Parameters:
WIDTH, 32, data word width in bits
MEM_SIZE, 32, number of words in the array
LATENCY, 2, cycles from request acceptance to resp_valid assertion (legal range 1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk edge)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  WIDTH  word address
req_wdata  input  WIDTH  store data
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  WIDTH  load data; 0 for stores and errors
resp_err  output  1  address was out of range
out_regs_bus  output  WIDTH*MEM_SIZE  word i at bits [WIDTH*(MEM_SIZE-i)-1 : WIDTH*(MEM_SIZE-i-1)], so word 0 is in the MSBs

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - All array words are cleared to 0, so out_regs_bus=0.
  - Latency counter is cleared.
  - Reset overrides any in-flight request; a pending response is dropped without a handshake.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/wdata and set counter=LATENCY-1.
  - If LATENCY==1, go directly to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1, perform the access and go to RESP.
  - The result is visible in resp_* on the first RESP cycle, exactly LATENCY cycles after the accept edge.
- Access rules, evaluated on the latched request:
  - Out of range (addr >= MEM_SIZE): no array change; resp_err=1, resp_rdata=0.
  - Store: array[addr] <= wdata; resp_rdata=0, resp_err=0.
  - Load: resp_rdata = array[addr] sampled at access time, resp_err=0.
  - A store updates out_regs_bus on the same edge that resp_valid rises.
- RESP:
  - resp_valid=1, req_ready=0; resp_rdata and resp_err are held stable until the handshake.
  - On resp_ready=1, go to IDLE next cycle and drop resp_valid.
  - Without resp_ready, stay in RESP indefinitely (backpressure).
- Single outstanding request; no new request is accepted until the response handshake completes. Back-to-back throughput is LATENCY+1 cycles per transaction.
- req_* inputs are ignored outside IDLE; the latched copies are used.
- resp_ready is ignored outside RESP.
- Address comparison uses the full WIDTH-bit req_addr; no wrap-around or aliasing.

Optional Feature:
MEM_RESPONDER_BYTE_STROBE_EN:
- When defined: adds input port req_be [WIDTH/8-1:0], latched with the request.
  - A store writes only bytes whose strobe is 1; byte k covers bits [8k+7:8k].
  - req_be==0 on a store gives a successful no-op (resp_err=0).
  - Loads ignore req_be.
- When undefined: the port is absent and stores write the full word.

Decomposition:
- Shared package mem_pkg holds:
  - state enum type (IDLE/WAIT/RESP);
  - localparam for the counter width, 4 bits;
  - constants DEFAULT_WIDTH=32 and DEFAULT_MEM_SIZE=32.
- One natural sub-module: mem_array.
  - MEM_SIZE x WIDTH storage with write-enable, optional byte strobes, and synchronous clear on reset.
  - Combinational read port.
  - Generates out_regs_bus in the layout above.
- The FSM and handshake logic stay in mem_responder.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release -> req_ready=1, resp_valid=0, out_regs_bus=0.
2. Store then load, LATENCY=2, resp_ready=1:
   - Store addr=16, wdata=0xDEADBEEF -> resp_valid exactly 2 cycles after accept, resp_err=0, word 16 slice of out_regs_bus = 0xDEADBEEF.
   - Load addr=16 -> resp_rdata=0xDEADBEEF.
3. Backpressure: load addr=0 with resp_ready=0 for 5 cycles -> resp_valid stays 1, resp_rdata stays 0, req_ready stays 0; raise resp_ready -> IDLE the next cycle.
4. Out of range: store addr=32, wdata=5 -> resp_err=1, resp_rdata=0, out_regs_bus unchanged.
5. Reset mid-WAIT: LATENCY=4, apply rst=0 one cycle after accepting store addr=3 -> no response ever issued, word 3=0, req_ready=1 after reset.
6. With MEM_RESPONDER_BYTE_STROBE_EN: store 0xFFFFFFFF to addr=1 with req_be=4'b0101 over a zeroed word -> word 1 reads back 0x00FF00FF.
